// File: rtl/port_queue_array.sv
// port_queue_array: an array of independent val/rdy FIFO queues, one per
// channel. Each channel buffers up to num_entries messages between a producer
// and a consumer and reports how many slots are still free. With pipe_mode set,
// a full queue can accept a new message in the same cycle it hands one out.
module port_queue_array #(
  parameter int nports      = 2,
  parameter int nbits       = 32,
  parameter int num_entries = 2,
  parameter bit pipe_mode   = 1'b0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [nbits-1:0]                   istream_msg [nports],
  input  logic                               istream_val [nports],
  output logic                               istream_rdy [nports],
  output logic [nbits-1:0]                   ostream_msg [nports],
  output logic                               ostream_val [nports],
  input  logic                               ostream_rdy [nports],
  output logic [$clog2(num_entries+1)-1:0]   num_free    [nports]
);

  // Pointers need at least one bit even for a single-entry queue.
  localparam int PtrW = (num_entries > 1) ? $clog2(num_entries) : 1;
  localparam int CntW = $clog2(num_entries + 1);

  localparam logic [CntW-1:0] Depth   = CntW'(num_entries);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(num_entries - 1);

  // Reject degenerate configurations before anything gets built.
  if (nports < 1 || num_entries < 1) begin : g_param_check
    $error("port_queue_array: nports and num_entries must both be at least 1");
  end

  for (genvar p = 0; p < nports; p++) begin : g_chan
    logic [nbits-1:0] storage_q [num_entries];
    logic [PtrW-1:0]  enq_ptr_q, enq_ptr_d;
    logic [PtrW-1:0]  deq_ptr_q, deq_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             full, empty, enq_rdy;
    logic             enq_fire, deq_fire;

    // Handshake view of this channel; only istream_rdy may look at an input
    // (ostream_rdy, and only in pipe mode), everything on ostream is pure state.
    always_comb begin
      full     = (count_q == Depth);
      empty    = (count_q == '0);
      enq_rdy  = !full || (pipe_mode && ostream_rdy[p]);
      enq_fire = istream_val[p] && enq_rdy;
      deq_fire = !empty && ostream_rdy[p];
    end

    assign istream_rdy[p] = enq_rdy;
    assign ostream_val[p] = !empty;
    assign ostream_msg[p] = storage_q[deq_ptr_q];
    assign num_free[p]    = Depth - count_q;

    // Next pointer and occupancy values; pointers wrap explicitly so depths
    // that are not a power of two still cycle through exactly num_entries slots.
    always_comb begin
      enq_ptr_d = enq_ptr_q;
      deq_ptr_d = deq_ptr_q;
      count_d   = count_q;
      if (enq_fire) begin
        enq_ptr_d = (enq_ptr_q == LastPtr) ? '0 : enq_ptr_q + PtrW'(1);
      end
      if (deq_fire) begin
        deq_ptr_d = (deq_ptr_q == LastPtr) ? '0 : deq_ptr_q + PtrW'(1);
      end
      case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end

    // Control state: reset empties the queue, discarding anything buffered.
    always_ff @(posedge clk) begin
      if (reset) begin
        enq_ptr_q <= '0;
        deq_ptr_q <= '0;
        count_q   <= '0;
      end else begin
        enq_ptr_q <= enq_ptr_d;
        deq_ptr_q <= deq_ptr_d;
        count_q   <= count_d;
      end
    end

    // Message storage is never cleared; the old slot value is what a
    // simultaneous pipe-mode read sees, since the write lands at the edge.
    always_ff @(posedge clk) begin
      if (enq_fire) begin
        storage_q[enq_ptr_q] <= istream_msg[p];
      end
    end

    // Occupancy must never exceed the queue depth.
    always_ff @(posedge clk) begin
      if (!reset) begin
        assert (count_q <= Depth);
      end
    end
  end

endmodule

// File: tb/tb_port_queue_array.sv
// Testbench for port_queue_array: four differently configured instances are
// driven in turn and compared against queue-based reference models.
module tb_port_queue_array;

  logic clk = 1'b0;
  logic reset;
  int   nChecks = 0;
  int   nFails  = 0;

  // Free-running clock.
  always #5 clk = ~clk;

  // Instance A: 2 ports, 32 bits, depth 2, normal mode
  logic [31:0] aIMsg [2];
  logic        aIVal [2];
  logic        aIRdy [2];
  logic [31:0] aOMsg [2];
  logic        aOVal [2];
  logic        aORdy [2];
  logic [1:0]  aFree [2];

  // Instance P: 1 port, 8 bits, depth 2, pipe mode
  logic [7:0]  pIMsg [1];
  logic        pIVal [1];
  logic        pIRdy [1];
  logic [7:0]  pOMsg [1];
  logic        pOVal [1];
  logic        pORdy [1];
  logic [1:0]  pFree [1];

  // Instance W: 1 port, 8 bits, depth 3 (non power of two)
  logic [7:0]  wIMsg [1];
  logic        wIVal [1];
  logic        wIRdy [1];
  logic [7:0]  wOMsg [1];
  logic        wOVal [1];
  logic        wORdy [1];
  logic [1:0]  wFree [1];

  // Instance I: 4 ports, 16 bits, depth 2
  logic [15:0] iIMsg [4];
  logic        iIVal [4];
  logic        iIRdy [4];
  logic [15:0] iOMsg [4];
  logic        iOVal [4];
  logic        iORdy [4];
  logic [1:0]  iFree [4];

  port_queue_array #(.nports(2), .nbits(32), .num_entries(2), .pipe_mode(1'b0)) dutA (
    .clk(clk), .reset(reset),
    .istream_msg(aIMsg), .istream_val(aIVal), .istream_rdy(aIRdy),
    .ostream_msg(aOMsg), .ostream_val(aOVal), .ostream_rdy(aORdy),
    .num_free(aFree)
  );

  port_queue_array #(.nports(1), .nbits(8), .num_entries(2), .pipe_mode(1'b1)) dutP (
    .clk(clk), .reset(reset),
    .istream_msg(pIMsg), .istream_val(pIVal), .istream_rdy(pIRdy),
    .ostream_msg(pOMsg), .ostream_val(pOVal), .ostream_rdy(pORdy),
    .num_free(pFree)
  );

  port_queue_array #(.nports(1), .nbits(8), .num_entries(3), .pipe_mode(1'b0)) dutW (
    .clk(clk), .reset(reset),
    .istream_msg(wIMsg), .istream_val(wIVal), .istream_rdy(wIRdy),
    .ostream_msg(wOMsg), .ostream_val(wOVal), .ostream_rdy(wORdy),
    .num_free(wFree)
  );

  port_queue_array #(.nports(4), .nbits(16), .num_entries(2), .pipe_mode(1'b0)) dutI (
    .clk(clk), .reset(reset),
    .istream_msg(iIMsg), .istream_val(iIVal), .istream_rdy(iIRdy),
    .ostream_msg(iOMsg), .ostream_val(iOVal), .ostream_rdy(iORdy),
    .num_free(iFree)
  );

  task automatic idleAll();
    for (int c = 0; c < 2; c++) begin aIVal[c] = 1'b0; aORdy[c] = 1'b0; aIMsg[c] = '0; end
    for (int c = 0; c < 4; c++) begin iIVal[c] = 1'b0; iORdy[c] = 1'b0; iIMsg[c] = '0; end
    pIVal[0] = 1'b0; pORdy[0] = 1'b0; pIMsg[0] = '0;
    wIVal[0] = 1'b0; wORdy[0] = 1'b0; wIMsg[0] = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    idleAll();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idleAll();
    reset = 1'b1;
    tick();
    tick();
    // still in reset: every instance shows an empty queue
    nChecks++; if (pOVal[0] !== 1'b0 || pIRdy[0] !== 1'b1 || pFree[0] !== 2'd2) begin nFails++; $display("[TB] FAIL reset_P: val=%b rdy=%b free=%0d required val=0 rdy=1 free=2", pOVal[0], pIRdy[0], pFree[0]); end
    nChecks++; if (wOVal[0] !== 1'b0 || wIRdy[0] !== 1'b1 || wFree[0] !== 2'd3) begin nFails++; $display("[TB] FAIL reset_W: val=%b rdy=%b free=%0d required val=0 rdy=1 free=3", wOVal[0], wIRdy[0], wFree[0]); end
    for (int c = 0; c < 4; c++) begin
      nChecks++; if (iOVal[c] !== 1'b0 || iIRdy[c] !== 1'b1 || iFree[c] !== 2'd2) begin nFails++; $display("[TB] FAIL reset_I ch%0d: val=%b rdy=%b free=%0d required val=0 rdy=1 free=2", c, iOVal[c], iIRdy[c], iFree[c]); end
    end
    reset = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      for (int c = 0; c < 2; c++) begin
        nChecks++; if (aOVal[c] !== 1'b0 || aIRdy[c] !== 1'b1 || aFree[c] !== 2'd2) begin nFails++; $display("[TB] FAIL idle_A ch%0d cyc%0d: val=%b rdy=%b free=%0d required val=0 rdy=1 free=2", c, cyc, aOVal[c], aIRdy[c], aFree[c]); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] offered [3];
    logic        expRdy  [7];
    logic        expVal  [7];
    logic [31:0] expMsg  [7];
    logic [1:0]  expFree [7];
    logic        drvVal  [7];
    logic [31:0] drvMsg  [7];
    logic        drvORdy [7];
    doReset();
    offered[0] = 32'hA; offered[1] = 32'hB; offered[2] = 32'hC;
    // cycle-by-cycle table: A,B fill, C stalls, then drain A, B (C enters), C
    drvVal  = '{1, 1, 1, 1, 1, 0, 0};
    drvMsg  = '{offered[0], offered[1], offered[2], offered[2], offered[2], 32'h0, 32'h0};
    drvORdy = '{0, 0, 0, 1, 1, 1, 1};
    expRdy  = '{1, 1, 0, 0, 1, 1, 1};
    expVal  = '{0, 1, 1, 1, 1, 1, 0};
    expMsg  = '{32'h0, offered[0], offered[0], offered[0], offered[1], offered[2], 32'h0};
    expFree = '{2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
    for (int cyc = 0; cyc < 7; cyc++) begin
      aIVal[0] = drvVal[cyc]; aIMsg[0] = drvMsg[cyc]; aORdy[0] = drvORdy[cyc];
      aORdy[1] = 1'b1;
      #1;
      nChecks++; if (aIRdy[0] !== expRdy[cyc]) begin nFails++; $display("[TB] FAIL bp_rdy cyc%0d: got %b required %b", cyc, aIRdy[0], expRdy[cyc]); end
      nChecks++; if (aOVal[0] !== expVal[cyc]) begin nFails++; $display("[TB] FAIL bp_val cyc%0d: got %b required %b", cyc, aOVal[0], expVal[cyc]); end
      nChecks++; if (aFree[0] !== expFree[cyc]) begin nFails++; $display("[TB] FAIL bp_free cyc%0d: got %0d required %0d", cyc, aFree[0], expFree[cyc]); end
      if (expVal[cyc]) begin
        nChecks++; if (aOMsg[0] !== expMsg[cyc]) begin nFails++; $display("[TB] FAIL bp_msg cyc%0d: got %0h required %0h", cyc, aOMsg[0], expMsg[cyc]); end
      end
      nChecks++; if (aOVal[1] !== 1'b0 || aFree[1] !== 2'd2) begin nFails++; $display("[TB] FAIL bp_ch1_idle cyc%0d: val=%b free=%0d required val=0 free=2", cyc, aOVal[1], aFree[1]); end
      tick();
    end
    idleAll();
  endtask

  task automatic test_pipe();
    doReset();
    pORdy[0] = 1'b0;
    pIVal[0] = 1'b1; pIMsg[0] = 8'h11; tick();
    pIMsg[0] = 8'h22; tick();
    pIVal[0] = 1'b1; pIMsg[0] = 8'h33; #1;
    nChecks++; if (pIRdy[0] !== 1'b0) begin nFails++; $display("[TB] FAIL pipe_full_stall: rdy got %b required 0", pIRdy[0]); end
    pORdy[0] = 1'b1; #1;
    nChecks++; if (pIRdy[0] !== 1'b1) begin nFails++; $display("[TB] FAIL pipe_full_rdy: rdy got %b required 1", pIRdy[0]); end
    nChecks++; if (pOMsg[0] !== 8'h11 || pFree[0] !== 2'd0) begin nFails++; $display("[TB] FAIL pipe_head: msg=%0h free=%0d required msg=11 free=0", pOMsg[0], pFree[0]); end
    tick();
    pIVal[0] = 1'b0; #1;
    nChecks++; if (pOVal[0] !== 1'b1 || pOMsg[0] !== 8'h22 || pFree[0] !== 2'd0) begin nFails++; $display("[TB] FAIL pipe_second: val=%b msg=%0h free=%0d required val=1 msg=22 free=0", pOVal[0], pOMsg[0], pFree[0]); end
    tick();
    nChecks++; if (pOVal[0] !== 1'b1 || pOMsg[0] !== 8'h33 || pFree[0] !== 2'd1) begin nFails++; $display("[TB] FAIL pipe_third: val=%b msg=%0h free=%0d required val=1 msg=33 free=1", pOVal[0], pOMsg[0], pFree[0]); end
    tick();
    nChecks++; if (pOVal[0] !== 1'b0 || pFree[0] !== 2'd2) begin nFails++; $display("[TB] FAIL pipe_empty: val=%b free=%0d required val=0 free=2", pOVal[0], pFree[0]); end
    idleAll();
  endtask

  task automatic test_wrap();
    logic [7:0] wq [$];
    int  sent = 0;
    int  got  = 0;
    int  cyc  = 0;
    logic expRdy;
    doReset();
    while (got < 10 && cyc < 300) begin
      wIVal[0] = (sent < 10) && ($urandom_range(0, 3) != 0);
      wIMsg[0] = 8'(sent);
      wORdy[0] = 1'($urandom_range(0, 1));
      #1;
      expRdy = (wq.size() != 3);
      nChecks++; if (wIRdy[0] !== expRdy) begin nFails++; $display("[TB] FAIL wrap_rdy cyc%0d: got %b required %b", cyc, wIRdy[0], expRdy); end
      nChecks++; if (wOVal[0] !== (wq.size() != 0)) begin nFails++; $display("[TB] FAIL wrap_val cyc%0d: got %b required %b", cyc, wOVal[0], wq.size() != 0); end
      nChecks++; if (wFree[0] !== 2'(3 - wq.size())) begin nFails++; $display("[TB] FAIL wrap_free cyc%0d: got %0d required %0d", cyc, wFree[0], 3 - wq.size()); end
      if (wq.size() != 0) begin
        nChecks++; if (wOMsg[0] !== wq[0]) begin nFails++; $display("[TB] FAIL wrap_msg cyc%0d: got %0d required %0d", cyc, wOMsg[0], wq[0]); end
        if (wORdy[0]) begin
          nChecks++; if (wOMsg[0] !== 8'(got)) begin nFails++; $display("[TB] FAIL wrap_order: got %0d required %0d", wOMsg[0], got); end
          void'(wq.pop_front());
          got++;
        end
      end
      if (wIVal[0] && expRdy) begin
        wq.push_back(wIMsg[0]);
        sent++;
      end
      tick();
      cyc++;
    end
    nChecks++; if (got != 10) begin nFails++; $display("[TB] FAIL wrap_timeout: delivered %0d required 10", got); end
    idleAll();
  endtask

  task automatic test_independent();
    logic [15:0] iq [4][$];
    int          delivered [4];
    logic [15:0] first2;
    logic [15:0] second2;
    logic        expRdy;
    doReset();
    first2 = '0;
    second2 = '0;
    for (int c = 0; c < 4; c++) begin
      delivered[c] = 0;
      iORdy[c] = (c != 2);
    end
    for (int cyc = 0; cyc < 10; cyc++) begin
      for (int c = 0; c < 4; c++) begin
        iIVal[c] = 1'b1;
        iIMsg[c] = 16'($urandom);
      end
      if (cyc == 0) first2 = iIMsg[2];
      if (cyc == 1) second2 = iIMsg[2];
      #1;
      for (int c = 0; c < 4; c++) begin
        expRdy = (iq[c].size() != 2);
        nChecks++; if (iIRdy[c] !== expRdy) begin nFails++; $display("[TB] FAIL ind_rdy ch%0d cyc%0d: got %b required %b", c, cyc, iIRdy[c], expRdy); end
        nChecks++; if (iFree[c] !== 2'(2 - iq[c].size())) begin nFails++; $display("[TB] FAIL ind_free ch%0d cyc%0d: got %0d required %0d", c, cyc, iFree[c], 2 - iq[c].size()); end
        if (iq[c].size() != 0) begin
          nChecks++; if (iOVal[c] !== 1'b1 || iOMsg[c] !== iq[c][0]) begin nFails++; $display("[TB] FAIL ind_head ch%0d cyc%0d: val=%b msg=%0h required val=1 msg=%0h", c, cyc, iOVal[c], iOMsg[c], iq[c][0]); end
        end
        if (iOVal[c] && iORdy[c]) delivered[c]++;
        if (iq[c].size() != 0 && iORdy[c]) void'(iq[c].pop_front());
        if (expRdy) iq[c].push_back(iIMsg[c]);
      end
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      if (c != 2) begin
        nChecks++; if (delivered[c] != 9) begin nFails++; $display("[TB] FAIL ind_rate ch%0d: delivered %0d required 9", c, delivered[c]); end
      end
    end
    iIVal[2] = 1'b0;
    iORdy[2] = 1'b1;
    #1;
    nChecks++; if (iOMsg[2] !== first2 || iFree[2] !== 2'd0) begin nFails++; $display("[TB] FAIL ind_hold_first: msg=%0h free=%0d required msg=%0h free=0", iOMsg[2], iFree[2], first2); end
    tick();
    nChecks++; if (iOMsg[2] !== second2 || iOVal[2] !== 1'b1) begin nFails++; $display("[TB] FAIL ind_hold_second: msg=%0h val=%b required msg=%0h val=1", iOMsg[2], iOVal[2], second2); end
    idleAll();
  endtask

  task automatic test_midreset();
    doReset();
    aIVal[0] = 1'b1; aIMsg[0] = 32'h55;
    aIVal[1] = 1'b1; aIMsg[1] = 32'h77;
    tick();
    aIVal[1] = 1'b0;
    aIMsg[0] = 32'h66;
    tick();
    aIVal[0] = 1'b0;
    #1;
    nChecks++; if (aFree[0] !== 2'd0 || aFree[1] !== 2'd1) begin nFails++; $display("[TB] FAIL mr_prefill: free0=%0d free1=%0d required 0 and 1", aFree[0], aFree[1]); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      nChecks++; if (aOVal[c] !== 1'b0 || aFree[c] !== 2'd2 || aIRdy[c] !== 1'b1) begin nFails++; $display("[TB] FAIL mr_cleared ch%0d: val=%b free=%0d rdy=%b required val=0 free=2 rdy=1", c, aOVal[c], aFree[c], aIRdy[c]); end
    end
    aORdy[0] = 1'b1; aORdy[1] = 1'b1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      tick();
      nChecks++; if (aOVal[0] !== 1'b0 || aOVal[1] !== 1'b0) begin nFails++; $display("[TB] FAIL mr_no_stale cyc%0d: val0=%b val1=%b required 0 0", cyc, aOVal[0], aOVal[1]); end
    end
    aORdy[0] = 1'b0; aORdy[1] = 1'b0;
    for (int c = 0; c < 2; c++) begin aIVal[c] = 1'b1; aIMsg[c] = 32'h88 + 32'(c); end
    tick();
    aIVal[0] = 1'b0; aIVal[1] = 1'b0;
    #1;
    for (int c = 0; c < 2; c++) begin
      nChecks++; if (aOVal[c] !== 1'b1 || aOMsg[c] !== 32'h88 + 32'(c)) begin nFails++; $display("[TB] FAIL mr_fresh ch%0d: val=%b msg=%0h required val=1 msg=%0h", c, aOVal[c], aOMsg[c], 32'h88 + 32'(c)); end
    end
    idleAll();
  endtask

  task automatic test_random();
    logic [31:0] qa [2][$];
    logic [7:0]  qp [$];
    logic        expRdy;
    doReset();
    for (int cyc = 0; cyc < 120; cyc++) begin
      for (int c = 0; c < 2; c++) begin
        aIVal[c] = 1'($urandom_range(0, 1));
        aIMsg[c] = $urandom;
        aORdy[c] = 1'($urandom_range(0, 1));
      end
      pIVal[0] = 1'($urandom_range(0, 1));
      pIMsg[0] = 8'($urandom);
      pORdy[0] = 1'($urandom_range(0, 1));
      #1;
      for (int c = 0; c < 2; c++) begin
        expRdy = (qa[c].size() != 2);
        nChecks++; if (aIRdy[c] !== expRdy || aOVal[c] !== (qa[c].size() != 0) || aFree[c] !== 2'(2 - qa[c].size())) begin nFails++; $display("[TB] FAIL rnd_A_ctl ch%0d cyc%0d: rdy=%b val=%b free=%0d required rdy=%b occupancy=%0d", c, cyc, aIRdy[c], aOVal[c], aFree[c], expRdy, qa[c].size()); end
        if (qa[c].size() != 0) begin
          nChecks++; if (aOMsg[c] !== qa[c][0]) begin nFails++; $display("[TB] FAIL rnd_A_msg ch%0d cyc%0d: got %0h required %0h", c, cyc, aOMsg[c], qa[c][0]); end
          if (aORdy[c]) void'(qa[c].pop_front());
        end
        if (aIVal[c] && expRdy) qa[c].push_back(aIMsg[c]);
      end
      expRdy = (qp.size() != 2) || pORdy[0];
      nChecks++; if (pIRdy[0] !== expRdy || pOVal[0] !== (qp.size() != 0) || pFree[0] !== 2'(2 - qp.size())) begin nFails++; $display("[TB] FAIL rnd_P_ctl cyc%0d: rdy=%b val=%b free=%0d required rdy=%b occupancy=%0d", cyc, pIRdy[0], pOVal[0], pFree[0], expRdy, qp.size()); end
      if (qp.size() != 0) begin
        nChecks++; if (pOMsg[0] !== qp[0]) begin nFails++; $display("[TB] FAIL rnd_P_msg cyc%0d: got %0h required %0h", cyc, pOMsg[0], qp[0]); end
        if (pORdy[0]) void'(qp.pop_front());
      end
      if (pIVal[0] && expRdy) qp.push_back(pIMsg[0]);
      tick();
    end
    idleAll();
  endtask

  // Test sequence.
  initial begin
    reset = 1'b1;
    idleAll();
    $display("[TB] starting port_queue_array tests");
    test_reset();
    test_backpressure();
    test_pipe();
    test_wrap();
    test_independent();
    test_midreset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
